// File: rtl/eth_ipv4_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eth_ipv4_framer                                               |
// | Description : Builds an Ethernet II + IPv4 header (34 bytes) from latched   |
// |               frame metadata and prepends it to an L4 byte stream. The      |
// |               stream is length-checked against the metadata.               |
// | Options     : ETH_FRAMER_PAD_EN - zero-pad short frames to 60 bytes        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eth_ipv4_framer (
  input  logic        clk,
  input  logic        rst,
  input  logic        meta_valid,
  output logic        meta_ready,
  input  logic [47:0] meta_dst_mac,
  input  logic [47:0] meta_src_mac,
  input  logic [31:0] meta_src_ip,
  input  logic [31:0] meta_dst_ip,
  input  logic [7:0]  meta_protocol,
  input  logic [15:0] meta_payload_len,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        busy,
  output logic        err_len
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CSUM    = 3'd1,
    HDR     = 3'd2,
    PAYLOAD = 3'd3,
    DRAIN   = 3'd4,
    PAD     = 3'd5
  } state_t;

  localparam logic [5:0]  c_hdr_last = 6'd33;   // index of final header byte
  localparam logic [15:0] c_pad_last = 16'd25;  // L4+pad bytes numbered 0..25 make 60 total

  state_t        state_q, state_d;
  logic [47:0]   dst_mac_q, src_mac_q;
  logic [31:0]   src_ip_q, dst_ip_q;
  logic [7:0]    proto_q;
  logic [15:0]   len_q;
  logic [15:0]   ident_q, ident_d;
  logic [15:0]   hdr_ident_q, hdr_ident_d;
  logic [15:0]   csum_q, csum_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic          err_len_q, err_len_d;

  logic          w_meta_load;
  logic          w_need_pad;
  logic          w_cnt_last;
  logic [15:0]   w_total_len;
  logic [19:0]   w_sum_raw;
  logic [16:0]   w_sum_f1;
  logic [15:0]   w_sum_f2;
  logic [271:0]  w_hdr_vec;
  logic [271:0]  w_hdr_shift;

`ifdef ETH_FRAMER_PAD_EN
  assign w_need_pad = (len_q < 16'd26);
`else
  assign w_need_pad = 1'b0;
`endif

  assign w_total_len = len_q + 16'd20;
  assign w_cnt_last  = (cnt_q == (len_q - 16'd1));

  // Header checksum: ten words (checksum field zero), two folds absorb all carries
  assign w_sum_raw = 20'h04500 + {4'h0, w_total_len} + {4'h0, ident_q} + 20'h04000
                   + {4'h0, 8'h40, proto_q}
                   + {4'h0, src_ip_q[31:16]} + {4'h0, src_ip_q[15:0]}
                   + {4'h0, dst_ip_q[31:16]} + {4'h0, dst_ip_q[15:0]};
  assign w_sum_f1  = {1'b0, w_sum_raw[15:0]} + {13'h0, w_sum_raw[19:16]};
  assign w_sum_f2  = w_sum_f1[15:0] + {15'h0, w_sum_f1[16]};

  assign w_hdr_vec   = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, w_total_len,
                        hdr_ident_q, 16'h4000, 8'h40, proto_q, csum_q, src_ip_q, dst_ip_q};
  assign w_hdr_shift = w_hdr_vec << {idx_q, 3'b000};

  assign busy    = (state_q != IDLE);
  assign err_len = err_len_q;

  // Next-state and output decode; outputs depend only on state and pass-through inputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    ident_d       = ident_q;
    hdr_ident_d   = hdr_ident_q;
    csum_d        = csum_q;
    err_len_d     = 1'b0;
    w_meta_load   = 1'b0;
    meta_ready    = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'h00;
    m_axis_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        meta_ready = ~rst;
        if (meta_valid && !rst) begin
          w_meta_load = 1'b1;
          idx_d       = 6'd0;
          cnt_d       = 16'd0;
          state_d     = CSUM;
        end
      end
      CSUM: begin
        csum_d      = ~w_sum_f2;
        hdr_ident_d = ident_q;
        ident_d     = ident_q + 16'd1;
        state_d     = HDR;
      end
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = w_hdr_shift[271:264];
        m_axis_tlast  = (idx_q == c_hdr_last) && (len_q == 16'd0) && !w_need_pad;
        if (m_axis_tready) begin
          if (idx_q == c_hdr_last) begin
            if (len_q != 16'd0)  state_d = PAYLOAD;
            else if (w_need_pad) state_d = PAD;
            else                 state_d = IDLE;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      PAYLOAD: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = (s_axis_tlast && !w_cnt_last) || (w_cnt_last && !w_need_pad);
        if (s_axis_tvalid && m_axis_tready) begin
          cnt_d = cnt_q + 16'd1;
          if (w_cnt_last) begin
            if (!s_axis_tlast) begin
              err_len_d = 1'b1;
              state_d   = DRAIN;
            end else if (w_need_pad) begin
              state_d = PAD;
            end else begin
              state_d = IDLE;
            end
          end else if (s_axis_tlast) begin
            // Sender ended early: frame closes on this byte, never padded
            err_len_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = w_need_pad ? PAD : IDLE;
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = (cnt_q == c_pad_last);
        if (m_axis_tready) begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == c_pad_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and error pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 6'd0;
      cnt_q       <= 16'd0;
      ident_q     <= 16'd0;
      hdr_ident_q <= 16'd0;
      csum_q      <= 16'd0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ident_q     <= ident_d;
      hdr_ident_q <= hdr_ident_d;
      csum_q      <= csum_d;
      err_len_q   <= err_len_d;
    end
  end

  // Metadata capture on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_mac_q <= 48'd0;
      src_mac_q <= 48'd0;
      src_ip_q  <= 32'd0;
      dst_ip_q  <= 32'd0;
      proto_q   <= 8'd0;
      len_q     <= 16'd0;
    end else if (w_meta_load) begin
      dst_mac_q <= meta_dst_mac;
      src_mac_q <= meta_src_mac;
      src_ip_q  <= meta_src_ip;
      dst_ip_q  <= meta_dst_ip;
      proto_q   <= meta_protocol;
      len_q     <= meta_payload_len;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eth_ipv4_framer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_eth_ipv4_framer                                            |
// | Description : Directed self-checking bench for eth_ipv4_framer             |
// |               (honours ETH_FRAMER_PAD_EN when defined)                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_eth_ipv4_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic        meta_valid;
  logic        meta_ready;
  logic [47:0] meta_dst_mac, meta_src_mac;
  logic [31:0] meta_src_ip, meta_dst_ip;
  logic [7:0]  meta_protocol;
  logic [15:0] meta_payload_len;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic        busy, err_len;

  localparam logic [47:0] c_dmac = 48'h02_11_22_33_44_55;
  localparam logic [47:0] c_smac = 48'h02_AA_BB_CC_DD_EE;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  pay [0:255];
  logic [7:0]  got [$];
  logic        got_last [$];
  logic [7:0]  exp_q [$];
  int          err_pulses, hold_viol, first_valid_cyc, last_si, nlast, mism, w;
  bit          timed_out, end_meta_ready, csum_cyc_valid;

  eth_ipv4_framer dut (
    .clk(clk), .rst(rst),
    .meta_valid(meta_valid), .meta_ready(meta_ready),
    .meta_dst_mac(meta_dst_mac), .meta_src_mac(meta_src_mac),
    .meta_src_ip(meta_src_ip), .meta_dst_ip(meta_dst_ip),
    .meta_protocol(meta_protocol), .meta_payload_len(meta_payload_len),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic fill_pay(input logic [7:0] seed);
    for (int i = 0; i < 256; i++) pay[i] = 8'(i * 13) ^ seed;
  endtask

  // Reference frame: header bytes, checksum summed from header byte pairs, payload, optional pad
  task automatic build_exp(input logic [15:0] len, input logic [15:0] ident,
                           input logic [31:0] sip, input logic [31:0] dip,
                           input logic [7:0] proto, input int npay, input bit allow_pad);
    logic [15:0] tl;
    logic [31:0] sum;
    exp_q.delete();
    tl = len + 16'd20;
    for (int i = 5; i >= 0; i--) exp_q.push_back(c_dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) exp_q.push_back(c_smac[i*8 +: 8]);
    exp_q.push_back(8'h08); exp_q.push_back(8'h00);
    exp_q.push_back(8'h45); exp_q.push_back(8'h00);
    exp_q.push_back(tl[15:8]); exp_q.push_back(tl[7:0]);
    exp_q.push_back(ident[15:8]); exp_q.push_back(ident[7:0]);
    exp_q.push_back(8'h40); exp_q.push_back(8'h00);
    exp_q.push_back(8'h40); exp_q.push_back(proto);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    for (int i = 3; i >= 0; i--) exp_q.push_back(sip[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(dip[i*8 +: 8]);
    sum = 0;
    for (int i = 14; i < 34; i += 2) sum += {16'h0, exp_q[i], exp_q[i+1]};
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    sum = ~sum;
    exp_q[24] = sum[15:8];
    exp_q[25] = sum[7:0];
    for (int i = 0; i < npay; i++) exp_q.push_back(pay[i]);
`ifdef ETH_FRAMER_PAD_EN
    if (allow_pad) while (exp_q.size() < 60) exp_q.push_back(8'h00);
`else
    if (allow_pad) exp_q = exp_q;
`endif
  endtask

  task automatic send_meta(input logic [15:0] len, input logic [31:0] sip,
                           input logic [31:0] dip, input logic [7:0] proto);
    meta_dst_mac = c_dmac; meta_src_mac = c_smac;
    meta_src_ip = sip; meta_dst_ip = dip;
    meta_protocol = proto; meta_payload_len = len;
    meta_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!meta_ready && w < 50) begin @(negedge clk); w++; end
    chk("meta_ready", {31'd0, meta_ready}, 32'd1);
    @(posedge clk); #1;
    meta_valid = 1'b0;
    @(negedge clk);
    csum_cyc_valid = m_axis_tvalid;
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int nsend, input int tlast_at, input bit stall);
    int si;
    bit done, prev_stall, prev_l;
    logic [7:0] prev_d;
    got.delete(); got_last.delete();
    err_pulses = 0; hold_viol = 0; first_valid_cyc = -1;
    si = 0; done = 0; prev_stall = 0; prev_d = 8'h00; prev_l = 0;
    timed_out = 1; end_meta_ready = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      s_axis_tvalid = (si < nsend);
      s_axis_tdata  = (si < nsend) ? pay[si] : 8'h00;
      s_axis_tlast  = (si < nsend) && (si == tlast_at - 1);
      m_axis_tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (err_len) err_pulses++;
      if (prev_stall && !(m_axis_tvalid && m_axis_tdata === prev_d && m_axis_tlast === prev_l))
        hold_viol++;
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_d = m_axis_tdata;
      prev_l = m_axis_tlast;
      if (m_axis_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        got.push_back(m_axis_tdata);
        got_last.push_back(m_axis_tlast);
        if (m_axis_tlast) done = 1;
      end
      if (s_axis_tvalid && s_axis_tready) si++;
      if (done && !busy && si == nsend) begin
        timed_out = 0;
        end_meta_ready = meta_ready;
      end
      @(posedge clk); #1;
      if (!timed_out) break;
    end
    last_si = si;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
  endtask

  task automatic check_frame(input string tag, input int exp_err);
    chk({tag, "_timeout"}, {31'd0, timed_out}, 32'd0);
    chk({tag, "_len"}, got.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got.size() || got[i] !== exp_q[i]) mism++;
    chk({tag, "_byte_mismatches"}, mism, 0);
    nlast = 0;
    foreach (got_last[i]) if (got_last[i]) nlast++;
    chk({tag, "_tlast_count"}, nlast, 1);
    chk({tag, "_tlast_final"}, (got_last.size() > 0) ? {31'd0, got_last[got_last.size()-1]} : 32'd0, 32'd1);
    chk({tag, "_err_pulses"}, err_pulses, exp_err);
  endtask

  initial begin
    rst = 1'b1; meta_valid = 1'b0;
    meta_dst_mac = '0; meta_src_mac = '0; meta_src_ip = '0; meta_dst_ip = '0;
    meta_protocol = '0; meta_payload_len = '0;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_meta_ready", {31'd0, meta_ready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err_len", {31'd0, err_len}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_meta_ready", {31'd0, meta_ready}, 32'd1);
    @(posedge clk); #1;

    // Reference frame: 192.168.0.1 -> 192.168.0.199, UDP, 95 bytes
    fill_pay(8'h5A);
    send_meta(16'd95, 32'hC0A80001, 32'hC0A800C7, 8'h11);
    chk("A_csum_cycle_tvalid", {31'd0, csum_cyc_valid}, 32'd0);
    run_frame(95, 95, 1'b0);
    chk("A_first_byte_cycle", first_valid_cyc, 0);
    build_exp(16'd95, 16'h0000, 32'hC0A80001, 32'hC0A800C7, 8'h11, 95, 1'b1);
    check_frame("A", 0);
    chk("A_bytecount", got.size(), 129);
    chk("A_total_len", (got.size() > 17) ? {16'd0, got[16], got[17]} : 32'hDEAD, 32'h0073);
    chk("A_ident", (got.size() > 19) ? {16'd0, got[18], got[19]} : 32'hDEAD, 32'h0000);
    chk("A_checksum", (got.size() > 25) ? {16'd0, got[24], got[25]} : 32'hDEAD, 32'hB861);
    chk("A_meta_ready_after", {31'd0, end_meta_ready}, 32'd1);

    // Back-to-back with random output stalls
    fill_pay(8'hC3);
    send_meta(16'd40, 32'h0A000001, 32'h0A000002, 8'h06);
    run_frame(40, 40, 1'b1);
    build_exp(16'd40, 16'h0001, 32'h0A000001, 32'h0A000002, 8'h06, 40, 1'b1);
    check_frame("B", 0);
    chk("B_ident", (got.size() > 19) ? {16'd0, got[18], got[19]} : 32'hDEAD, 32'h0001);
    chk("B_hold_violations", hold_viol, 0);

    // Sender ends early: length 10, tlast on byte 6
    fill_pay(8'h11);
    send_meta(16'd10, 32'hAC100001, 32'hAC100002, 8'h11);
    run_frame(6, 6, 1'b0);
    build_exp(16'd10, 16'h0002, 32'hAC100001, 32'hAC100002, 8'h11, 6, 1'b0);
    check_frame("C", 1);
    chk("C_bytecount", got.size(), 40);

    // Sender overruns: length 4, 8 bytes sent, 4 drained
    fill_pay(8'h77);
    send_meta(16'd4, 32'hAC100003, 32'hAC100004, 8'h11);
    run_frame(8, 8, 1'b1);
    build_exp(16'd4, 16'h0003, 32'hAC100003, 32'hAC100004, 8'h11, 4, 1'b1);
    check_frame("D", 1);
    chk("D_consumed", last_si, 8);

    // Empty payload
    send_meta(16'd0, 32'h01020304, 32'h05060708, 8'h01);
    run_frame(0, 0, 1'b0);
    build_exp(16'd0, 16'h0004, 32'h01020304, 32'h05060708, 8'h01, 0, 1'b1);
    check_frame("E", 0);
`ifdef ETH_FRAMER_PAD_EN
    chk("E_bytecount", got.size(), 60);
`else
    chk("E_bytecount", got.size(), 34);
`endif

    // Reset while header byte 20 is presented
    fill_pay(8'h99);
    send_meta(16'd30, 32'hC0A80101, 32'hC0A80102, 8'h11);
    m_axis_tready = 1'b1;
    w = 0;
    while (w < 19) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk); #2;
    chk("R_pre_tvalid", {31'd0, m_axis_tvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("R_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("R_busy", {31'd0, busy}, 32'd0);
    chk("R_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("R_meta_ready", {31'd0, meta_ready}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    fill_pay(8'h3C);
    send_meta(16'd20, 32'hC0A80105, 32'hC0A80106, 8'h06);
    run_frame(20, 20, 1'b0);
    build_exp(16'd20, 16'h0000, 32'hC0A80105, 32'hC0A80106, 8'h06, 20, 1'b1);
    check_frame("F", 0);
    chk("F_ident", (got.size() > 19) ? {16'd0, got[18], got[19]} : 32'hDEAD, 32'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eth_ipv4_framer.md
ETH_IPV4_FRAMER -- requirements
Module: eth_ipv4_framer

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: meta_valid in 1, meta_ready out 1  frame-metadata handshake.
REQ-004 SHALL have ports: meta_dst_mac in 48, meta_src_mac in 48, meta_src_ip in 32, meta_dst_ip in 32, meta_protocol in 8, meta_payload_len in 16  (L4 byte count).
REQ-005 SHALL have ports: s_axis_tdata in 8, s_axis_tvalid in 1, s_axis_tready out 1, s_axis_tlast in 1  L4 segment bytes from sender.
REQ-006 SHALL have ports: m_axis_tdata out 8, m_axis_tvalid out 1, m_axis_tready in 1, m_axis_tlast out 1  frame bytes to PHY.
REQ-007 SHALL have ports: busy out 1  (state != IDLE); err_len out 1  one-cycle length-mismatch pulse.

Function
REQ-008 SHALL use states IDLE, CSUM, HDR, PAYLOAD, DRAIN, PAD.
REQ-009 IDLE: meta_ready=1; on meta_valid&meta_ready latch all meta fields, go CSUM.
REQ-010 CSUM (exactly one cycle): compute IPv4 header checksum, go HDR; first header byte valid 2 cycles after metadata acceptance.
REQ-011 HDR SHALL emit 34 bytes MSB-first: dst_mac(6), src_mac(6), 0x0800, 0x45, 0x00, total_len=20+payload_len (16b, mod 2^16), ident(16), 0x4000, TTL 0x40, protocol, checksum(16), src_ip(4), dst_ip(4).
REQ-012 Checksum SHALL be ones-complement of 16-bit ones-complement sum of the ten header words with checksum field 0, carries folded until none remain.
REQ-013 ident SHALL be a 16-bit counter, reset 0, incremented on leaving CSUM, wrapping 0xFFFF->0x0000.
REQ-014 m_axis_tdata/tvalid/tlast SHALL hold stable while tvalid=1 and tready=0; byte advances only on tvalid&tready.
REQ-015 PAYLOAD SHALL pass through combinationally: m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, data unchanged; s_axis_tready=0 in all other states.
REQ-016 Payload byte counter (16b) SHALL make the byte numbered payload_len the last; tlast on it unless padding applies (REQ-021).
REQ-017 Input tlast before count reached: that byte output with m_axis_tlast=1, err_len pulses, go IDLE, no padding.
REQ-018 Count reached without input tlast: err_len pulses, go DRAIN; DRAIN sets s_axis_tready=1, discards bytes through input tlast, then IDLE.
REQ-019 payload_len=0: PAYLOAD skipped; tlast on last header byte (or pad byte).
REQ-020 After final frame byte accepted, return IDLE; meta_ready rises next cycle (no back-to-back overlap).

Configuration
REQ-021 With ETH_FRAMER_PAD_EN defined: if 34+payload_len<60, PAD state emits 0x00 bytes until total frame = 60 bytes, tlast on byte 60; without it PAD is never entered and frames may be shorter than 60 bytes.

Reset
REQ-022 On rst asserted (any time, including mid-frame) SHALL asynchronously force: state IDLE, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, meta_ready=0 while rst=1 then 1 in IDLE, busy=0, err_len=0, ident=0, counters=0.
REQ-023 A frame interrupted by reset SHALL not resume; next frame starts fresh from metadata.

Verification
REQ-024 First frame after reset, src 192.168.0.1, dst 192.168.0.199, protocol 0x11, payload_len 95 -> total_len 0x0073, ident 0x0000, checksum 0xB861, 129 bytes, tlast on byte 129.
REQ-025 Two back-to-back frames -> ident 0x0000 then 0x0001; ident preloaded path wraps 0xFFFF->0x0000 after 65536 frames.
REQ-026 Random m_axis_tready stalls during HDR and PAYLOAD -> output stream byte-identical to unstalled run, data held while stalled.
REQ-027 payload_len 10, input tlast on byte 6 -> frame 40 bytes, tlast on byte 40, err_len one pulse; payload_len 4, 8 bytes sent -> 38-byte frame, 4 bytes drained, err_len pulse.
REQ-028 ETH_FRAMER_PAD_EN, payload_len 0 -> 60-byte frame, bytes 35-60 = 0x00, tlast on 60; without macro -> 34 bytes, tlast on 34.
REQ-029 rst asserted at header byte 20 -> m_axis_tvalid=0 same cycle, busy=0; next frame correct with ident 0x0000.
